// File: rtl/lbp_window_fetch.sv
// lbp_window_fetch: streams each 3x3 neighbourhood of the image into the window
// register bank and hands full windows to the LBP stage. Option: LBP_FETCH_STALL_CNT_EN.
module lbp_window_fetch #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DATA_W-1:0] gray_data,
    output logic [DATA_W-1:0] win_data,
    output logic [8:0]        win_en,
    output logic              win_valid,
    input  logic              win_ack,
    output logic [ADDR_W-1:0] center_addr,
    output logic              done
`ifdef LBP_FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LAST,
        S_VALID,
        S_DONE
    } state_t;

    localparam logic [15:0] C_LAST = 16'(IMG_W - 2);
    localparam logic [15:0] R_LAST = 16'(IMG_H - 2);

    state_t      state;
    logic [15:0] r;
    logic [15:0] c;
    logic [3:0]  k;
    logic [1:0]  kr;
    logic [1:0]  kc;

    logic [1:0]        nkr;
    logic [1:0]        nkc;
    logic [15:0]       r_nx;
    logic [15:0]       c_nx;
    logic              last_win;
    logic [ADDR_W-1:0] addr_next;

    function automatic logic [ADDR_W-1:0] pix(
        input logic [15:0] row,
        input logic [15:0] col
    );
        return ADDR_W'(32'(row) * 32'(IMG_W) + 32'(col));
    endfunction

    assign win_data = gray_data;

    // Next slot inside the window and next window center in raster order
    always_comb begin
        nkr = kr;
        nkc = kc + 2'd1;
        if (kc == 2'd2) begin
            nkr = kr + 2'd1;
            nkc = 2'd0;
        end
        r_nx = r;
        c_nx = c + 16'd1;
        if (c == C_LAST) begin
            r_nx = r + 16'd1;
            c_nx = 16'd1;
        end
        last_win  = (r == R_LAST) && (c == C_LAST);
        addr_next = pix(r - 16'd1 + {14'd0, nkr},
                        c - 16'd1 + {14'd0, nkc});
    end

    // Fetch sequencer: all outputs registered, win_en trails gray_req by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            r           <= 16'd1;
            c           <= 16'd1;
            k           <= 4'd0;
            kr          <= 2'd0;
            kc          <= 2'd0;
            gray_req    <= 1'b0;
            gray_addr   <= '0;
            win_en      <= 9'd0;
            win_valid   <= 1'b0;
            center_addr <= '0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (gray_ready) begin
                        state       <= S_REQ;
                        k           <= 4'd0;
                        kr          <= 2'd0;
                        kc          <= 2'd0;
                        gray_req    <= 1'b1;
                        gray_addr   <= pix(r - 16'd1, c - 16'd1);
                        center_addr <= pix(r, c);
                    end
                end
                S_REQ: begin
                    win_en <= 9'd1 << k;
                    if (k == 4'd8) begin
                        gray_req <= 1'b0;
                        state    <= S_LAST;
                    end else begin
                        k         <= k + 4'd1;
                        kr        <= nkr;
                        kc        <= nkc;
                        gray_addr <= addr_next;
                    end
                end
                S_LAST: begin
                    win_en    <= 9'd0;
                    win_valid <= 1'b1;
                    state     <= S_VALID;
                end
                S_VALID: begin
                    if (win_ack) begin
                        win_valid <= 1'b0;
                        r         <= r_nx;
                        c         <= c_nx;
                        if (last_win) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= S_REQ;
                            k           <= 4'd0;
                            kr          <= 2'd0;
                            kc          <= 2'd0;
                            gray_req    <= 1'b1;
                            gray_addr   <= pix(r_nx - 16'd1, c_nx - 16'd1);
                            center_addr <= pix(r_nx, c_nx);
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LBP_FETCH_STALL_CNT_EN
    // Saturating count of cycles a full window waits on the compute stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (state == S_VALID && !win_ack && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lbp_window_fetch.sv
// tb_lbp_window_fetch: randomized bench for lbp_window_fetch on a 4x4 image;
// memory model returns data = address.
module tb_lbp_window_fetch;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          gray_ready = 1'b0;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data = '0;
    logic [DW-1:0] win_data;
    logic [8:0]    win_en;
    logic          win_valid;
    logic          win_ack = 1'b0;
    logic [AW-1:0] center_addr;
    logic          done;
`ifdef LBP_FETCH_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    lbp_window_fetch #(
        .IMG_W(W),
        .IMG_H(H),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gray_ready(gray_ready),
        .gray_req(gray_req),
        .gray_addr(gray_addr),
        .gray_data(gray_data),
        .win_data(win_data),
        .win_en(win_en),
        .win_valid(win_valid),
        .win_ack(win_ack),
        .center_addr(center_addr),
        .done(done)
`ifdef LBP_FETCH_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Image memory: one-cycle read latency, data equals address
    always @(posedge clk) begin
        if (gray_req) gray_data <= {4'd0, gray_addr};
    end

    function automatic int exp_addr(input int r, input int c, input int k);
        return ((r - 1 + k / 3) * W + (c - 1 + k % 3)) % (1 << AW);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        gray_ready = 1'b0;
        win_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Walks one whole window from its first request cycle to win_valid
    task automatic check_window(input int r, input int c, input bit rnd);
        logic [8:0] een;
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (gray_req !== (j < 9)) begin
                errors++;
                $display("FAIL win_req r%0d c%0d j%0d: got %b want %b", r, c, j, gray_req, j < 9);
            end
            if (j < 9) begin
                checks++;
                if (gray_addr !== AW'(exp_addr(r, c, j))) begin
                    errors++;
                    $display("FAIL win_addr r%0d c%0d j%0d: got %0d want %0d", r, c, j, gray_addr, exp_addr(r, c, j));
                end
            end
            een = (j == 0) ? 9'd0 : (9'd1 << (j - 1));
            checks++;
            if (win_en !== een) begin
                errors++;
                $display("FAIL win_en r%0d c%0d j%0d: got %h want %h", r, c, j, win_en, een);
            end
            if (j > 0) begin
                checks++;
                if (win_data !== DW'(exp_addr(r, c, j - 1))) begin
                    errors++;
                    $display("FAIL win_data r%0d c%0d j%0d: got %0d want %0d", r, c, j, win_data, exp_addr(r, c, j - 1));
                end
            end
            checks++;
            if (win_valid !== 1'b0) begin
                errors++;
                $display("FAIL win_valid_early r%0d c%0d j%0d: got %b want 0", r, c, j, win_valid);
            end
            if (j == 0) begin
                checks++;
                if (center_addr !== AW'(r * W + c)) begin
                    errors++;
                    $display("FAIL center r%0d c%0d: got %0d want %0d", r, c, center_addr, r * W + c);
                end
            end
            if (rnd) begin
                gray_ready = 1'($urandom % 2);
                win_ack = 1'($urandom % 2);
            end else begin
                win_ack = 1'b0;
            end
            tick();
        end
        win_ack = 1'b0;
        checks++;
        if (win_valid !== 1'b1 || gray_req !== 1'b0 || win_en !== 9'd0) begin
            errors++;
            $display("FAIL valid_state r%0d c%0d: got v=%b req=%b en=%h want 1 0 000", r, c, win_valid, gray_req, win_en);
        end
        checks++;
        if (center_addr !== AW'(r * W + c)) begin
            errors++;
            $display("FAIL center_valid r%0d c%0d: got %0d want %0d", r, c, center_addr, r * W + c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if ({gray_req, gray_addr, win_en, win_valid, center_addr, done} !== '0) begin
            errors++;
            $display("FAIL reset_state: got req=%b addr=%0d en=%h v=%b ctr=%0d done=%b want all 0", gray_req, gray_addr, win_en, win_valid, center_addr, done);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_window();
        apply_reset();
        gray_ready = 1'b1;
        tick();
        check_window(1, 1, 1'b0);
    endtask

    task automatic test_backpressure();
        apply_reset();
        gray_ready = 1'b1;
        tick();
        check_window(1, 1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (win_valid !== 1'b1 || gray_req !== 1'b0 || win_en !== 9'd0) begin
                errors++;
                $display("FAIL backpressure i%0d: got v=%b req=%b en=%h want 1 0 000", i, win_valid, gray_req, win_en);
            end
            tick();
        end
        win_ack = 1'b1;
        tick();
        checks++;
        if (win_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_drop: got %b want 0", win_valid);
        end
        check_window(1, 2, 1'b0);
    endtask

    task automatic test_full_scan();
        int rq[$];
        int cq[$];
        int n;
        for (int r = 1; r <= H - 2; r++)
            for (int c = 1; c <= W - 2; c++) begin
                rq.push_back(r);
                cq.push_back(c);
            end
        apply_reset();
        gray_ready = 1'b1;
        tick();
        for (int i = 0; i < rq.size(); i++) begin
            check_window(rq[i], cq[i], 1'b1);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_early i%0d: got %b want 0", i, done);
            end
            n = $urandom_range(0, 3);
            repeat (n) tick();
            win_ack = 1'b1;
            tick();
            win_ack = 1'b0;
        end
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (done !== 1'b1 || gray_req !== 1'b0 || win_valid !== 1'b0 || win_en !== 9'd0) begin
                errors++;
                $display("FAIL done_hold i%0d: got done=%b req=%b v=%b en=%h want 1 0 0 000", i, done, gray_req, win_valid, win_en);
            end
            gray_ready = 1'($urandom % 2);
            win_ack = 1'($urandom % 2);
            tick();
        end
        win_ack = 1'b0;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        gray_ready = 1'b1;
        tick();
        repeat (4) tick();
        checks++;
        if (gray_addr !== AW'(exp_addr(1, 1, 4)) || win_en !== 9'h008) begin
            errors++;
            $display("FAIL mid_k4: got addr=%0d en=%h want %0d 008", gray_addr, win_en, exp_addr(1, 1, 4));
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({gray_req, gray_addr, win_en, win_valid, center_addr, done} !== '0) begin
            errors++;
            $display("FAIL mid_reset_zero: got req=%b addr=%0d en=%h v=%b ctr=%0d done=%b want all 0", gray_req, gray_addr, win_en, win_valid, center_addr, done);
        end
        gray_ready = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gray_req !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle i%0d: got %b want 0", i, gray_req);
            end
        end
        gray_ready = 1'b1;
        tick();
        check_window(1, 1, 1'b0);
    endtask

    task automatic test_gating();
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            win_ack = 1'($urandom % 2);
            tick();
            checks++;
            if (gray_req !== 1'b0) begin
                errors++;
                $display("FAIL gate_idle i%0d: got %b want 0", i, gray_req);
            end
        end
        win_ack = 1'b0;
        gray_ready = 1'b1;
        tick();
        check_window(1, 1, 1'b1);
        win_ack = 1'b1;
        tick();
        check_window(1, 2, 1'b1);
    endtask

`ifdef LBP_FETCH_STALL_CNT_EN
    task automatic test_stall_cnt();
        apply_reset();
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stall_reset: got %0d want 0", stall_cnt);
        end
        gray_ready = 1'b1;
        tick();
        check_window(1, 1, 1'b0);
        repeat (7) tick();
        win_ack = 1'b1;
        tick();
        win_ack = 1'b0;
        checks++;
        if (stall_cnt !== 16'd7) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 7", stall_cnt);
        end
        check_window(1, 2, 1'b1);
        checks++;
        if (stall_cnt !== 16'd7) begin
            errors++;
            $display("FAIL stall_hold: got %0d want 7", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_window();
        test_backpressure();
        test_full_scan();
        test_mid_reset();
        test_gating();
`ifdef LBP_FETCH_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
